// File: rtl/parity_stream_checker.sv
// Serial parity checker: accumulates DATA_W bits, compares against a trailing
// parity bit, and keeps a saturating count of mismatched frames.
module parity_stream_checker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic             InClk,
  input  logic             InRstN,
  input  logic             InStart,
  input  logic             InOdd,
  input  logic             InValid,
  input  logic             InBit,
  input  logic             InClrCnt,
  output logic             OutBusy,
  output logic             OutParity,
  output logic             OutDone,
  output logic             OutErr,
  output logic [CNT_W-1:0] OutErrCnt
);

  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    CHECK  = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               acc_q, acc_d;
  logic [BCW-1:0]     bcnt_q, bcnt_d;
  logic               par_q, par_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   errcnt_q, errcnt_d;
  logic               mismatch;

  always_ff @(posedge InClk or negedge InRstN) begin
    if (!InRstN) begin
      state_q  <= IDLE;
      acc_q    <= 1'b0;
      bcnt_q   <= '0;
      par_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      bcnt_q   <= bcnt_d;
      par_q    <= par_d;
      err_q    <= err_d;
      done_q   <= done_d;
      errcnt_q <= errcnt_d;
    end
  end

  // The mode is carried by seeding the accumulator with InOdd at frame start.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    bcnt_d   = bcnt_q;
    par_d    = par_q;
    err_d    = err_q;
    done_d   = 1'b0;
    errcnt_d = errcnt_q;
    mismatch = InBit ^ acc_q;

    unique case (state_q)
      IDLE: begin
        if (InStart) begin
          state_d = DATA;
          acc_d   = InOdd;
          bcnt_d  = '0;
        end
      end
      DATA: begin
        if (InValid) begin
          acc_d = acc_q ^ InBit;
          if (bcnt_q == LAST_BIT) begin
            state_d = CHECK;
          end else begin
            bcnt_d = bcnt_q + BCW'(1);
          end
        end
      end
      CHECK: begin
        if (InValid) begin
          par_d   = acc_q;
          err_d   = mismatch;
          done_d  = 1'b1;
          state_d = REPORT;
          if (mismatch && (errcnt_q != '1)) begin
            errcnt_d = errcnt_q + CNT_W'(1);
          end
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (InClrCnt) begin
      errcnt_d = '0;
    end
  end

  assign OutBusy   = (state_q != IDLE);
  assign OutParity = par_q;
  assign OutDone   = done_q;
  assign OutErr    = err_q;
  assign OutErrCnt = errcnt_q;

endmodule

// File: tb/tb_parity_stream_checker.sv
// Directed bench for parity_stream_checker with DATA_W=4, CNT_W=4; expected
// values are hand-computed from the frame definitions.
module tb_parity_stream_checker;

  logic       InClk = 1'b0;
  logic       InRstN = 1'b0;
  logic       InStart = 1'b0;
  logic       InOdd = 1'b0;
  logic       InValid = 1'b0;
  logic       InBit = 1'b0;
  logic       InClrCnt = 1'b0;
  logic       OutBusy;
  logic       OutParity;
  logic       OutDone;
  logic       OutErr;
  logic [3:0] OutErrCnt;

  int passed = 0;
  int total  = 0;

  parity_stream_checker #(.DATA_W(4), .CNT_W(4)) dut (
    .InClk     (InClk),
    .InRstN    (InRstN),
    .InStart   (InStart),
    .InOdd     (InOdd),
    .InValid   (InValid),
    .InBit     (InBit),
    .InClrCnt  (InClrCnt),
    .OutBusy   (OutBusy),
    .OutParity (OutParity),
    .OutDone   (OutDone),
    .OutErr    (OutErr),
    .OutErrCnt (OutErrCnt)
  );

  always #5 InClk = ~InClk;

  task automatic tick();
    @(posedge InClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Runs one frame up to and including the parity edge; returns in REPORT.
  task automatic frame(input logic odd, input logic [3:0] bits, input logic par,
                       input int unsigned gaps, input bit poke_start, input bit clr);
    InStart = 1'b1;
    InOdd   = odd;
    tick();
    InStart = 1'b0;
    InOdd   = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      InValid = 1'b0;
      for (int unsigned g = 0; g < gaps; g++) begin
        tick();
        chk("gap_busy", 32'(OutBusy), 32'd1);
      end
      InValid = 1'b1;
      InBit   = bits[i];
      if (poke_start && i == 2) begin
        InStart = 1'b1;
        InOdd   = ~odd;
      end
      tick();
      InStart = 1'b0;
      InOdd   = 1'b0;
    end
    InValid = 1'b0;
    for (int unsigned g = 0; g < gaps; g++) tick();
    chk("check_busy", 32'(OutBusy), 32'd1);
    chk("check_no_done", 32'(OutDone), 32'd0);
    InValid  = 1'b1;
    InBit    = par;
    InClrCnt = clr;
    tick();
    InValid  = 1'b0;
    InBit    = 1'b0;
    InClrCnt = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_busy", 32'(OutBusy), 32'd0);
    chk("rst_parity", 32'(OutParity), 32'd0);
    chk("rst_done", 32'(OutDone), 32'd0);
    chk("rst_err", 32'(OutErr), 32'd0);
    chk("rst_cnt", 32'(OutErrCnt), 32'd0);
    #10 InRstN = 1'b1;

    // Even frame 1,0,1,1 + parity 1: parity 1, no error
    frame(1'b0, 4'b1101, 1'b1, 0, 1'b0, 1'b0);
    chk("even_done", 32'(OutDone), 32'd1);
    chk("even_parity", 32'(OutParity), 32'd1);
    chk("even_err", 32'(OutErr), 32'd0);
    chk("even_cnt", 32'(OutErrCnt), 32'd0);
    chk("even_busy_report", 32'(OutBusy), 32'd1);
    tick();
    chk("even_done_pulse", 32'(OutDone), 32'd0);
    chk("even_idle", 32'(OutBusy), 32'd0);

    // Odd frame, same bits: parity 0, mismatch against received 1
    frame(1'b1, 4'b1101, 1'b1, 0, 1'b0, 1'b0);
    chk("odd_done", 32'(OutDone), 32'd1);
    chk("odd_parity", 32'(OutParity), 32'd0);
    chk("odd_err", 32'(OutErr), 32'd1);
    chk("odd_cnt", 32'(OutErrCnt), 32'd1);
    tick();
    tick();
    chk("odd_hold_parity", 32'(OutParity), 32'd0);
    chk("odd_hold_err", 32'(OutErr), 32'd1);

    // Even frame with 3-cycle valid gaps
    frame(1'b0, 4'b1101, 1'b1, 3, 1'b0, 1'b0);
    chk("gap_done", 32'(OutDone), 32'd1);
    chk("gap_parity", 32'(OutParity), 32'd1);
    chk("gap_err", 32'(OutErr), 32'd0);
    chk("gap_cnt", 32'(OutErrCnt), 32'd1);
    tick();

    // Clear, then 17 erroneous frames saturate at 15
    InClrCnt = 1'b1;
    tick();
    InClrCnt = 1'b0;
    chk("clr_cnt", 32'(OutErrCnt), 32'd0);
    for (int unsigned f = 1; f <= 17; f++) begin
      frame(1'b1, 4'b1101, 1'b1, 0, 1'b0, 1'b0);
      tick();
      if (f == 14) chk("sat_cnt14", 32'(OutErrCnt), 32'd14);
      if (f == 15) chk("sat_cnt15", 32'(OutErrCnt), 32'd15);
    end
    chk("sat_cnt17", 32'(OutErrCnt), 32'd15);

    // Clear coincident with an erroneous frame's REPORT entry: clear wins
    frame(1'b1, 4'b1101, 1'b1, 0, 1'b0, 1'b1);
    chk("clrwin_err", 32'(OutErr), 32'd1);
    chk("clrwin_cnt", 32'(OutErrCnt), 32'd0);
    tick();

    // Even data 0,1,1,1 (xor 1) with a received 0: error, count 1
    frame(1'b0, 4'b1110, 1'b0, 1, 1'b0, 1'b0);
    chk("even_bad_parity", 32'(OutParity), 32'd1);
    chk("even_bad_err", 32'(OutErr), 32'd1);
    chk("even_bad_cnt", 32'(OutErrCnt), 32'd1);
    tick();

    // Abort after 2 data bits
    InStart = 1'b1;
    InOdd   = 1'b0;
    tick();
    InStart = 1'b0;
    InValid = 1'b1;
    InBit   = 1'b1;
    tick();
    InBit   = 1'b0;
    tick();
    InValid = 1'b0;
    #2 InRstN = 1'b0;
    #1;
    chk("abort_busy", 32'(OutBusy), 32'd0);
    chk("abort_parity", 32'(OutParity), 32'd0);
    chk("abort_done", 32'(OutDone), 32'd0);
    chk("abort_err", 32'(OutErr), 32'd0);
    chk("abort_cnt", 32'(OutErrCnt), 32'd0);
    tick();
    chk("abort_done_hold", 32'(OutDone), 32'd0);
    #2 InRstN = 1'b1;
    frame(1'b1, 4'b0011, 1'b1, 0, 1'b0, 1'b0);
    chk("post_abort_done", 32'(OutDone), 32'd1);
    chk("post_abort_parity", 32'(OutParity), 32'd1);
    chk("post_abort_err", 32'(OutErr), 32'd0);
    chk("post_abort_cnt", 32'(OutErrCnt), 32'd0);

    // InStart pulsed in REPORT (now) and in DATA (next frame): both ignored
    InStart = 1'b1;
    InOdd   = 1'b1;
    tick();
    InStart = 1'b0;
    InOdd   = 1'b0;
    chk("report_start_idle", 32'(OutBusy), 32'd0);
    chk("report_start_nodone", 32'(OutDone), 32'd0);
    frame(1'b0, 4'b1101, 1'b1, 0, 1'b1, 1'b0);
    chk("poke_done", 32'(OutDone), 32'd1);
    chk("poke_parity", 32'(OutParity), 32'd1);
    chk("poke_err", 32'(OutErr), 32'd0);
    InStart = 1'b1;
    InOdd   = 1'b1;
    tick();
    InStart = 1'b0;
    chk("poke_report_idle", 32'(OutBusy), 32'd0);
    chk("poke_report_parity", 32'(OutParity), 32'd1);
    chk("poke_report_err", 32'(OutErr), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/parity_stream_checker.md
PARITY_STREAM_CHECKER -- requirements
Module: parity_stream_checker

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data bits per frame; legal range 1..64.
REQ-002 Parameter CNT_W, default 4, SHALL set the width of the error counter; legal range 1..16.
REQ-003 Port InClk, input, 1, SHALL be the single clock; all state changes on the rising edge.
REQ-004 Port InRstN, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-005 Port InStart, input, 1, SHALL request a new frame; it is accepted only in IDLE.
REQ-006 Port InOdd, input, 1, SHALL select the mode (0 even, 1 odd); it is sampled only when InStart is accepted.
REQ-007 Port InValid, input, 1, SHALL qualify InBit; a bit is consumed on each edge where InValid=1 in DATA or CHECK.
REQ-008 Port InBit, input, 1, SHALL carry the serial data or parity bit.
REQ-009 Port InClrCnt, input, 1, SHALL synchronously clear OutErrCnt.
REQ-010 Port OutBusy, output, 1, SHALL be 1 whenever the state is not IDLE.
REQ-011 Port OutParity, output, 1, SHALL hold the parity generated for the last completed frame.
REQ-012 Port OutDone, output, 1, SHALL be a one-cycle frame-complete pulse.
REQ-013 Port OutErr, output, 1, SHALL be the check result of the last completed frame (1 = mismatch).
REQ-014 Port OutErrCnt, output, CNT_W, SHALL be the saturating count of frames with a mismatch.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, DATA, CHECK, REPORT.
REQ-016 In IDLE with InStart=1, the FSM SHALL go to DATA, set the accumulator to InOdd, clear the bit counter and latch the mode.
REQ-017 In DATA, each edge with InValid=1 SHALL XOR InBit into the accumulator and increment the bit counter.
REQ-018 In DATA, the edge that consumes the DATA_W-th bit SHALL move the FSM to CHECK.
REQ-019 Edges with InValid=0 in DATA or CHECK SHALL hold all state; gaps are unlimited and there is no timeout.
REQ-020 In CHECK, an edge with InValid=1 SHALL treat InBit as the received parity bit.
REQ-021 On that CHECK edge: OutParity <= accumulator; OutErr <= (InBit != accumulator); OutDone <= 1; FSM -> REPORT.
REQ-022 In REPORT, OutDone SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge, with OutDone <= 0.
REQ-023 Latency: OutDone SHALL be high in the cycle immediately following the edge that consumes the parity bit.
REQ-024 Back-to-back frames: InStart may be asserted during REPORT; it is ignored, so the earliest new frame starts at the edge after REPORT, in IDLE.
REQ-025 InStart outside IDLE SHALL be ignored, with no effect on the accumulator, counter or mode.
REQ-026 OutErrCnt SHALL increment by 1 on the edge entering REPORT when the mismatch is 1, and saturate at 2^CNT_W-1 (no wrap).
REQ-027 InClrCnt=1 SHALL set OutErrCnt to 0 on the next edge; on a simultaneous increment, clear wins.
REQ-028 OutParity and OutErr SHALL hold their values until the next frame completes.
REQ-029 InBit and InOdd SHALL be don't-care outside the states in which they are sampled.

Reset
REQ-030 InRstN=0 SHALL immediately set: state IDLE, accumulator 0, bit counter 0, OutBusy 0, OutParity 0, OutDone 0, OutErr 0, OutErrCnt 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no OutDone pulse and no counter change.
REQ-032 After InRstN rises, the first frame MAY start on the first rising edge.

Verification (DATA_W=4, CNT_W=4)
REQ-033 Even frame: InOdd=0, bits 1,0,1,1, parity bit 1 -> OutParity=1, OutErr=0, OutErrCnt=0, OutDone one cycle after the parity edge.
REQ-034 Odd frame: InOdd=1, bits 1,0,1,1, parity bit 1 -> OutParity=0, OutErr=1, OutErrCnt=1.
REQ-035 Valid gaps: same even frame with InValid=0 for 3 cycles between each bit -> identical results; OutBusy=1 throughout.
REQ-036 Saturation and clear: 17 erroneous frames -> OutErrCnt=15; then InClrCnt together with an erroneous frame's REPORT entry -> OutErrCnt=0.
REQ-037 Abort: InRstN=0 after 2 data bits -> no OutDone, all outputs 0; the next full frame checks correctly.
REQ-038 InStart pulsed in DATA and in REPORT -> no effect on the current frame's OutParity or OutErr.
